// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
//
// Sits between the core's two-phase data-memory port and a simple
// req/gnt/rvalid bus. The core presents address and control while the
// instruction is in DX and the store data one cycle later, in WB. Each
// accepted access becomes exactly one bus transaction. Load data is shifted
// and extended, then returned to the core in the cycle the response arrives.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   dmem_en/wen/size    core request: valid, store flag, size (bit 2 = unsigned)
//   dmem_addr           byte address of the request
//   dmem_wdata_delayed  store data, valid from the cycle after acceptance
//   dmem_rdata          formatted load data (held between completions)
//   dmem_wait           stall to the core
//   dmem_badmem_e       misaligned request or bus error response
//   bus_req/gnt         address phase handshake
//   bus_we/addr/be      write flag, word-aligned address, byte enables
//   bus_wdata           store data replicated across byte lanes
//   bus_rvalid/rdata    response phase
//   bus_err             error flag, qualified by bus_rvalid
module vscale_dmem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dmem_en,
  input  logic                  dmem_wen,
  input  logic [2:0]            dmem_size,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_delayed,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_wait,
  output logic                  dmem_badmem_e,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [2:0]              size_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    cap_win;
  logic                    misaligned;
  logic                    capture;
  logic                    resp_done;
  logic [DATA_WIDTH-1:0]   load_val;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the store data means the slave can pick its lane purely
  // from bus_be, without looking at the low address bits.
  function automatic logic [DATA_WIDTH-1:0] lane_rep(input logic [2:0] size,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (size[1:0])
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [2:0] size,
                                                     input logic [1:0] off,
                                                     input logic [DATA_WIDTH-1:0] raw);
    logic [DATA_WIDTH-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size[1:0])
      2'd0:    return {{24{~size[2] & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{~size[2] & sh[15]}}, sh[15:0]};
      default: return raw;
    endcase
  endfunction

  // A new request can only be taken while idle or in the cycle the previous
  // response completes; anywhere else the core is being stalled and simply
  // holds its request. Reset closes the window so every output reads 0.
  always_comb begin
    cap_win    = ~reset & ((state == IDLE) | ((state == RESP) & bus_rvalid));
    misaligned = is_misaligned(dmem_size, dmem_addr[1:0]);
    capture    = cap_win & dmem_en & ~misaligned;
    resp_done  = (state == RESP) & bus_rvalid;
    load_val   = load_fmt(size_q, addr_q[1:0], bus_rdata);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = REQ;
      REQ:     if (bus_gnt) state_nxt = RESP;
      RESP:    if (bus_rvalid) state_nxt = capture ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req       = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_be        = 4'b0000;
    bus_wdata     = '0;
    dmem_wait     = 1'b0;
    dmem_badmem_e = (cap_win & dmem_en & misaligned) | (resp_done & bus_err);
    dmem_rdata    = resp_done ? load_val : rdata_q;
    case (state)
      REQ: begin
        bus_req   = 1'b1;
        bus_we    = wen_q;
        bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus_be    = byte_en(size_q, addr_q[1:0]);
        bus_wdata = lane_rep(size_q, dmem_wdata_delayed);
        dmem_wait = 1'b1;
      end
      RESP:    dmem_wait = ~bus_rvalid;
      default: ;
    endcase
  end

  // Request capture / response register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= 3'd0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q <= dmem_addr;
        wen_q  <= dmem_wen;
        size_q <= dmem_size;
      end
      if (resp_done) rdata_q <= load_val;
    end
  end

endmodule
